// File: rtl/product_accumulator_pkg.sv
// Shared types and constants for the product accumulator slice.
// The accumulator sums a fixed-size group of 8-bit multiplier products.
package product_accumulator_pkg;

   // Width of one product coming out of the 4x4 array multiplier
   localparam int PROD_W      = 8;

   // Default group size and accumulator width
   localparam int N_TERMS_DEF = 4;
   localparam int ACC_W_DEF   = 12;

   // Beat counter width for the default group size
   localparam int CNT_W       = $clog2(N_TERMS_DEF);

   // ACCUM: collecting the group; DONE: holding a finished sum for the consumer
   typedef enum logic {
      ST_ACCUM = 1'b0,
      ST_DONE  = 1'b1
   } acc_state_e;

   // Counter width for an arbitrary group size (never narrower than one bit)
   function automatic int cnt_width(input int n);
      return (n < 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/product_accumulator_acc.sv
// Ripple-carry adder: ACC_W-bit accumulator plus a zero-extended product.
// Built from one full-adder cell per bit, matching the multiplier array.
module acc_adder
   import product_accumulator_pkg::*;
#(
   parameter int ACC_W = ACC_W_DEF
) (
   input  logic [ACC_W-1:0]  i_acc,
   input  logic [PROD_W-1:0] i_prod,
   output logic [ACC_W-1:0]  o_sum,
   output logic              o_cout
);

   logic [ACC_W-1:0] w_b;
   logic [ACC_W:0]   w_c;

   // Upper bits of the second operand are zero
   assign w_b    = ACC_W'(i_prod);
   assign w_c[0] = 1'b0;

   genvar gi;
   generate
      for (gi = 0; gi < ACC_W; gi++) begin : g_fa
         // One full-adder cell: sum and carry from a, b, carry-in
         assign o_sum[gi]  = i_acc[gi] ^ w_b[gi] ^ w_c[gi];
         assign w_c[gi+1]  = (i_acc[gi] & w_b[gi]) |
                             (i_acc[gi] & w_c[gi]) |
                             (w_b[gi]   & w_c[gi]);
      end
   endgenerate

   assign o_cout = w_c[ACC_W];

endmodule

// File: rtl/product_accumulator.sv
// Product accumulator: sums N_TERMS products per group and hands the result
// to a downstream consumer with an overflow flag.
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high. Input side: in_ready depends only on state and clear, never on
// in_valid. Output side: out_valid is registered, and out_sum/out_ovf stay
// stable while out_valid is high until out_ready is seen.
module product_accumulator
   import product_accumulator_pkg::*;
#(
   parameter int N_TERMS = N_TERMS_DEF,
   parameter int ACC_W   = ACC_W_DEF
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              clear,
   input  logic [PROD_W-1:0] in_prod,
   input  logic              in_valid,
   output logic              in_ready,
   output logic [ACC_W-1:0]  out_sum,
   output logic              out_ovf,
   output logic              out_valid,
   input  logic              out_ready,
   output logic              o_dbg_state
);

   localparam int            CW   = cnt_width(N_TERMS);
   localparam logic [CW-1:0] LAST = CW'(N_TERMS - 1);

   acc_state_e       r_state;
   logic [ACC_W-1:0] r_acc;
   logic [CW-1:0]    r_cnt;
   logic             r_ovf;
   logic [ACC_W-1:0] r_out_sum;
   logic             r_out_ovf;
   logic             r_out_valid;

   logic             w_accept;
   logic [ACC_W-1:0] w_add_sum;
   logic             w_add_cout;
   logic [ACC_W-1:0] w_next_acc;
   logic             w_next_ovf;

   acc_adder #(
      .ACC_W (ACC_W)
   ) u_adder (
      .i_acc  (r_acc),
      .i_prod (in_prod),
      .o_sum  (w_add_sum),
      .o_cout (w_add_cout)
   );

   // Ready only while collecting, and never in a cycle that aborts the group
   assign in_ready = (r_state == ST_ACCUM) && !clear;
   assign w_accept = in_valid && in_ready;

   // Value the accumulator takes on an accepted beat; first beat restarts the group
   always_comb begin
      w_next_acc = w_add_sum;
      w_next_ovf = r_ovf | w_add_cout;
      if (r_cnt == '0) begin
         w_next_acc = ACC_W'(in_prod);
         w_next_ovf = 1'b0;
      end
   end

   // Group state machine: accumulate beats, then hold the result until taken
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state     <= ST_ACCUM;
         r_acc       <= '0;
         r_cnt       <= '0;
         r_ovf       <= 1'b0;
         r_out_sum   <= '0;
         r_out_ovf   <= 1'b0;
         r_out_valid <= 1'b0;
      end else begin
         case (r_state)
            ST_ACCUM: begin
               if (clear) begin
                  // Abort: partial sum is dropped; acc is reloaded by the next first beat
                  r_cnt <= '0;
                  r_ovf <= 1'b0;
               end else if (w_accept) begin
                  r_acc <= w_next_acc;
                  r_ovf <= w_next_ovf;
                  if (r_cnt == LAST) begin
                     r_cnt       <= '0;
                     r_out_sum   <= w_next_acc;
                     r_out_ovf   <= w_next_ovf;
                     r_out_valid <= 1'b1;
                     r_state     <= ST_DONE;
                  end else begin
                     r_cnt <= r_cnt + CW'(1);
                  end
               end
            end
            ST_DONE: begin
               // clear is ignored here; the pending result is always delivered
               if (out_ready) begin
                  r_out_valid <= 1'b0;
                  r_state     <= ST_ACCUM;
               end
            end
            default: begin
               r_state     <= ST_ACCUM;
               r_out_valid <= 1'b0;
            end
         endcase
      end
   end

   assign out_sum     = r_out_sum;
   assign out_ovf     = r_out_ovf;
   assign out_valid   = r_out_valid;
   assign o_dbg_state = r_state;

endmodule

// File: tb/tb_product_accumulator.sv
// Bench for product_accumulator: two instances (ACC_W=12 and ACC_W=8) share
// one stimulus stream. A group-level model predicts handshakes and sums.
module tb_product_accumulator;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        clear = 1'b0;
  logic [7:0]  in_prod = 8'd0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b1;

  logic        in_ready_a, out_ovf_a, out_valid_a, dbg_a;
  logic [11:0] out_sum_a;
  logic        in_ready_b, out_ovf_b, out_valid_b, dbg_b;
  logic [7:0]  out_sum_b;

  int n_checks = 0;
  int n_pass = 0;

  // model state: result pending, true (unwrapped) sum of last group, open group
  bit m_pending = 1'b0;
  int m_total = 0;
  int m_group[$];

  product_accumulator #(.N_TERMS(4), .ACC_W(12)) dut_a (
    .clk(clk), .rst_n(rst_n), .clear(clear), .in_prod(in_prod),
    .in_valid(in_valid), .in_ready(in_ready_a), .out_sum(out_sum_a),
    .out_ovf(out_ovf_a), .out_valid(out_valid_a), .out_ready(out_ready),
    .o_dbg_state(dbg_a)
  );

  product_accumulator #(.N_TERMS(4), .ACC_W(8)) dut_b (
    .clk(clk), .rst_n(rst_n), .clear(clear), .in_prod(in_prod),
    .in_valid(in_valid), .in_ready(in_ready_b), .out_sum(out_sum_b),
    .out_ovf(out_ovf_b), .out_valid(out_valid_b), .out_ready(out_ready),
    .o_dbg_state(dbg_b)
  );

  // clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", n_checks);
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  // compare + model step, mid-cycle while inputs and outputs are stable
  always @(negedge clk) begin
    logic exp_ready;
    int   s;
    exp_ready = !m_pending && !clear;
    chk("m_in_ready_a",  in_ready_a,  exp_ready);
    chk("m_in_ready_b",  in_ready_b,  exp_ready);
    chk("m_out_valid_a", out_valid_a, m_pending);
    chk("m_out_valid_b", out_valid_b, m_pending);
    chk("m_state_a",     dbg_a,       m_pending);
    chk("m_state_b",     dbg_b,       m_pending);
    chk("m_out_sum_a",   out_sum_a,   m_total % 4096);
    chk("m_out_ovf_a",   out_ovf_a,   m_total >= 4096);
    chk("m_out_sum_b",   out_sum_b,   m_total % 256);
    chk("m_out_ovf_b",   out_ovf_b,   m_total >= 256);
    // predict the effect of the coming rising edge
    if (!rst_n) begin
      m_pending = 1'b0;
      m_total = 0;
      m_group.delete();
    end else if (m_pending) begin
      if (out_ready) m_pending = 1'b0;
    end else if (clear) begin
      m_group.delete();
    end else if (in_valid) begin
      m_group.push_back(int'(in_prod));
      if (m_group.size() == 4) begin
        s = 0;
        foreach (m_group[k]) s += m_group[k];
        m_total = s;
        m_pending = 1'b1;
        m_group.delete();
      end
    end
  end

  // driver tasks: inputs change 1 time unit after the rising edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) step();
  endtask

  task automatic send(input logic [7:0] p);
    bit got;
    got = 1'b0;
    in_valid = 1'b1;
    in_prod = p;
    for (int t = 0; t < 50 && !got; t++) begin
      @(negedge clk);
      got = in_ready_a;
      step();
    end
    if (!got) chk("send_timeout", 32'd0, 32'd1);
    in_valid = 1'b0;
  endtask

  task automatic send4(input logic [7:0] a, input logic [7:0] b,
                       input logic [7:0] c, input logic [7:0] d);
    send(a); send(b); send(c); send(d);
  endtask

  // the cycle after the last beat: result must be presented
  task automatic expect_result(input string name, input int sa, input int oa,
                               input int sb, input int ob);
    @(negedge clk);
    chk({name, "_valid"}, out_valid_a, 1);
    chk({name, "_ready"}, in_ready_a, 0);
    chk({name, "_sum_a"}, out_sum_a, sa);
    chk({name, "_ovf_a"}, out_ovf_a, oa);
    chk({name, "_sum_b"}, out_sum_b, sb);
    chk({name, "_ovf_b"}, out_ovf_b, ob);
    step();
  endtask

  initial begin
    // reset
    idle(2);
    @(negedge clk);
    chk("rst_valid", out_valid_a, 0);
    chk("rst_sum", out_sum_a, 0);
    rst_n = 1'b1;
    step();
    @(negedge clk);
    chk("rst_ready", in_ready_a, 1);
    step();

    // 4 x 225 back to back: 900 fits 12 bits, wraps to 132 in 8 bits
    send4(8'd225, 8'd225, 8'd225, 8'd225);
    expect_result("g225", 900, 0, 132, 1);
    @(negedge clk);
    chk("g225_ready_back", in_ready_a, 1);
    chk("g225_valid_drop", out_valid_a, 0);
    step();

    // overflow flag does not carry into the next group
    send4(8'd1, 8'd1, 8'd1, 8'd1);
    expect_result("g1111", 4, 0, 4, 0);

    // consumer stalls for 5 cycles; extra beats are ignored
    out_ready = 1'b0;
    send4(8'd1, 8'd2, 8'd3, 8'd4);
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1;
      in_prod = 8'd77;
      @(negedge clk);
      chk("stall_sum", out_sum_a, 10);
      chk("stall_valid", out_valid_a, 1);
      chk("stall_ready", in_ready_a, 0);
      step();
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    chk("stall_release_sum", out_sum_a, 10);
    step();
    @(negedge clk);
    chk("stall_consumed", out_valid_a, 0);
    step();
    send4(8'd5, 8'd5, 8'd5, 8'd5);
    expect_result("g5555", 20, 0, 20, 0);

    // clear aborts a partial group and blocks the beat in the same cycle
    send(8'd10);
    send(8'd20);
    clear = 1'b1;
    in_valid = 1'b1;
    in_prod = 8'd99;
    @(negedge clk);
    chk("clear_ready", in_ready_a, 0);
    step();
    clear = 1'b0;
    in_valid = 1'b0;
    send4(8'd1, 8'd2, 8'd3, 8'd4);
    expect_result("g_after_clear", 10, 0, 10, 0);

    // random idle gaps inside a group
    send(8'd7);
    idle($urandom_range(0, 3));
    send(8'd8);
    idle($urandom_range(0, 3));
    send(8'd9);
    idle($urandom_range(0, 3));
    send(8'd6);
    expect_result("g_gaps", 30, 0, 30, 0);

    // reset mid-group
    send(8'd3);
    send(8'd4);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_mid_ready", in_ready_a, 1);
    chk("rst_mid_valid", out_valid_a, 0);
    chk("rst_mid_sum", out_sum_a, 0);
    step();

    // reset while holding a result
    out_ready = 1'b0;
    send4(8'd1, 8'd1, 8'd1, 8'd1);
    @(negedge clk);
    chk("rst_done_pre_valid", out_valid_a, 1);
    step();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    chk("rst_done_valid", out_valid_a, 0);
    chk("rst_done_sum", out_sum_a, 0);
    chk("rst_done_ovf", out_ovf_a, 0);
    chk("rst_done_ready", in_ready_a, 1);
    step();
    send4(8'd2, 8'd2, 8'd2, 8'd2);
    expect_result("g2222", 8, 0, 8, 0);
    idle(2);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
